// File: rtl/logic_pipe_if.sv
// rtl/logic_pipe_if.sv - operand/result handshake bundle for logic_pipe
interface logic_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             parity;

    modport master (
        output in_valid, op, a, b, acc_clr, out_ready,
        input  in_ready, out_valid, y, parity
    );

    modport slave (
        input  in_valid, op, a, b, acc_clr, out_ready,
        output in_ready, out_valid, y, parity
    );
endinterface

// File: rtl/logic_pipe.sv
// rtl/logic_pipe.sv - registered eight-op bitwise unit with XOR accumulator and valid/ready output
module logic_pipe #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    logic_pipe_if.slave   bus
);
    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_XNOR = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_ACC  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_eff;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] y_q;
    logic             parity_q;
    logic             ready;
    logic             accept;

    assign ready         = (state == EMPTY) || bus.out_ready;
    assign accept        = bus.in_valid && ready;
    assign bus.in_ready  = ready;
    assign bus.out_valid = (state == FULL);
    assign bus.y         = y_q;
    assign bus.parity    = parity_q;

    // A same-edge clear is folded in here so an ACC beat sees a zero accumulator.
    always_comb begin
        acc_eff = bus.acc_clr ? '0 : acc;
        result  = '0;
        case (op_e'(bus.op))
            OP_AND:  result = bus.a & bus.b;
            OP_OR:   result = bus.a | bus.b;
            OP_XOR:  result = bus.a ^ bus.b;
            OP_XNOR: result = ~(bus.a ^ bus.b);
            OP_NAND: result = ~(bus.a & bus.b);
            OP_NOR:  result = ~(bus.a | bus.b);
            OP_ACC:  result = acc_eff ^ bus.a;
            OP_PASS: result = bus.a;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            y_q      <= '0;
            parity_q <= 1'b0;
            acc      <= '0;
        end else begin
            if (accept) begin
                state    <= FULL;
                y_q      <= result;
                parity_q <= ^result;
            end else if (bus.out_ready) begin
                state <= EMPTY;
            end

            if (accept && (op_e'(bus.op) == OP_ACC)) begin
                acc <= result;
            end else if (bus.acc_clr) begin
                acc <= '0;
            end
        end
    end
endmodule
